// File: rtl/lc3_memory_responder.sv
// Memory-side responder for the LC3 memory port: latches a request, waits WAIT_STATES
// cycles, executes the read/write and pulses memRDY. Optional checker: LC3_MEM_PROTCHK_EN.
module lc3_memory_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       memory_addr,
  input  logic [DATA_W-1:0] memory_din,
  input  logic              memEN,
  input  logic              memWE,
  output logic [DATA_W-1:0] memory_dout,
  output logic              memRDY,
  output logic              memERR
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              latch, exec;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              we_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    exec      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (memEN) begin
          latch     = 1'b1;
          cnt_nxt   = WAIT_INIT;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A dropped request abandons the access before anything is committed.
        if (!memEN) begin
          cnt_nxt   = 4'd0;
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          exec      = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign memRDY = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      memory_dout <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) we_q <= memWE;
      if (exec && !we_q) memory_dout <= mem[addr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      addr_q <= memory_addr[ADDR_W-1:0];
      din_q  <= memory_din;
    end
  end

  // Array is intentionally not reset; exec is low whenever reset holds state in IDLE.
  always_ff @(posedge clk) begin
    if (exec && we_q) mem[addr_q] <= din_q;
  end

`ifdef LC3_MEM_PROTCHK_EN
  logic err_q;
  logic viol;

  assign viol = (state == S_WAIT) &&
                (!memEN || (memory_addr[ADDR_W-1:0] != addr_q) || (memWE != we_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end

  assign memERR = err_q;
`else
  assign memERR = 1'b0;
`endif

endmodule
